addsub_share_arb: RTL and testbench
===================================

Name: addsub_share_arb

Overview:
- Sequences a single shared add/subtract execution unit between NUM_REQ client modules.
- Clients currently each own a dedicated adder or subtractor function; this block replaces that with one registered add/sub datapath.
- Arbitration is round-robin with valid/ready request and response handshakes.
- Sits between client modules and the shared arithmetic; one operation in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
EXEC_CYCLES, 1, execute-phase duration in cycles (>=1)
IDX_W, $clog2(NUM_REQ), width of the round-robin pointer (derived, not overridden)

Ports:
i_clk  input  1  clock, all state on rising edge
i_arst_n  input  1  reset, asynchronous assert, active-low
i_req_valid  input  NUM_REQ  per-requester request valid
o_req_ready  output  NUM_REQ  per-requester request accept (at most one bit set)
i_req_op  input  NUM_REQ  per-requester op: 0=add (a+b), 1=subtract (a-b)
i_req_a  input  NUM_REQ*32  operand a, requester k at bits [32k+31:32k]
i_req_b  input  NUM_REQ*32  operand b, same packing
o_rsp_valid  output  NUM_REQ  one-hot response valid to the granted requester
i_rsp_ready  input  NUM_REQ  per-requester response accept
o_rsp_data  output  32  result, meaningful only while o_rsp_valid != 0
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (i_arst_n low, asynchronous):
  - state=IDLE; o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0.
  - Last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
  - Operand/op registers cleared; EXEC counter=0.
  - Reset mid-operation discards the operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search i_req_valid starting at (last_grant+1) mod NUM_REQ, wrapping.
  - The first set bit g wins; o_req_ready[g]=1 combinationally in that cycle. All other ready bits are 0.
  - No valid bits set: o_req_ready=0, stay in IDLE.
  - On the edge: capture op[g], a[g], b[g]; grant register=g; last_grant=g; counter=EXEC_CYCLES-1; go to EXEC.
- EXEC:
  - Lasts exactly EXEC_CYCLES cycles, with the counter decrementing.
  - On the edge where counter==0: o_rsp_data is registered as a+b (op=0) or a-b (op=1); go to RESP.
  - Arithmetic is 32-bit two's complement, wraps modulo 2^32, with no saturation and no overflow flag.
- RESP:
  - o_rsp_valid[g]=1 and o_rsp_data are held stable until i_rsp_ready[g]=1.
  - On that edge: clear o_rsp_valid and go to IDLE.
  - i_rsp_ready bits of non-granted requesters are ignored.
- Latency and throughput:
  - Request handshake in cycle T gives o_rsp_valid high from cycle T+EXEC_CYCLES+1.
  - IDLE is always visited between operations, so the minimum spacing between grants is EXEC_CYCLES+2 cycles.
- o_req_ready is 0 in EXEC and RESP. New requests are never accepted while busy.
- Client protocol:
  - A requester holds valid, op and operands stable until it sees ready.
  - Changes to valid/op/operands of non-granted requesters have no effect.
- Simultaneous requests are resolved only by the round-robin pointer. Continuous requests from all clients are served in strict rotation: no starvation, maximum wait NUM_REQ-1 operations.
- o_busy is registered from state (IDLE→0, EXEC/RESP→1).

Test Plan:
1. Single add: reset, then req0 valid, op=0, a=5, b=7 with i_rsp_ready=1 → o_req_ready[0]=1 in cycle T; o_rsp_valid=2'b01, o_rsp_data=12 in cycle T+2; IDLE in T+3.
2. Subtract wrap: req1 op=1, a=0, b=1 → o_rsp_valid=2'b10, o_rsp_data=32'hFFFF_FFFF; add overflow a=32'h7FFF_FFFF, b=1 → 32'h8000_0000.
3. Contention: both requesters held valid continuously after reset, req0 add 1+1, req1 sub 9-4 → grants alternate 0,1,0,1; responses 2,5,2,5; grants spaced 3 cycles apart.
4. Backpressure: i_rsp_ready[0]=0 for 5 cycles during RESP with req1 valid → o_rsp_data stable, o_req_ready=0, o_busy=1 throughout; req1 is granted only after i_rsp_ready[0] rises and the FSM returns to IDLE.
5. Wrong-ready ignored: in RESP for requester 0, assert i_rsp_ready=2'b10 → no exit; then 2'b01 → exit to IDLE.
6. Async reset mid-EXEC (EXEC_CYCLES=4, reset asserted in the 2nd EXEC cycle, not on a clock edge) → all outputs 0 immediately; after release with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/addsub_share_arb.sv
// Round-robin arbiter that time-shares one registered 32-bit add/subtract unit
// between NUM_REQ clients, with valid/ready handshakes on requests and responses.
module addsub_share_arb #(
  parameter int NUM_REQ     = 2,
  parameter int EXEC_CYCLES = 1,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ-1:0]      i_req_op,
  input  logic [NUM_REQ*32-1:0]   i_req_a,
  input  logic [NUM_REQ*32-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  input  logic [NUM_REQ-1:0]      i_rsp_ready,
  output logic [31:0]             o_rsp_data,
  output logic                    o_busy
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;

  logic               pick_found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [31:0]        req_a_s [NUM_REQ];
  logic [31:0]        req_b_s [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] addsub(input logic op, input logic [31:0] a,
                                         input logic [31:0] b);
    if (op) begin
      return a - b;
    end else begin
      return a + b;
    end
  endfunction

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_a_s[k] = i_req_a[k*32 +: 32];
      req_b_s[k] = i_req_b[k*32 +: 32];
    end
  end

  // Round-robin search starting just after the last grant, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found_s && i_req_valid[IDX_W'((int'(last_q) + i) % NUM_REQ)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'((int'(last_q) + i) % NUM_REQ);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Ready is combinational in IDLE; held low while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    if ((state_q == ST_IDLE) && pick_found_s && i_arst_n) begin
      o_req_ready[pick_idx_s] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Next-state and datapath computation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_EXEC;
          gnt_d   = pick_idx_s;
          last_d  = pick_idx_s;
          op_d    = i_req_op[pick_idx_s];
          a_d     = req_a_s[pick_idx_s];
          b_d     = req_b_s[pick_idx_s];
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_data_d  = addsub(op_q, a_q, b_q);
          rsp_valid_d = onehot(gnt_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Only the granted requester's ready can complete the response.
        if (i_rsp_ready[gnt_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = '0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      op_q        <= 1'b0;
      a_q         <= 32'h0000_0000;
      b_q         <= 32'h0000_0000;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_addsub_share_arb.sv
// Scoreboard bench for addsub_share_arb: a transaction-level model predicts grants,
// timing and results; a separate monitor checks each response against the queue.
module tb_addsub_share_arb;

  localparam int N  = 3;
  localparam int EC = 3;

  typedef struct packed { logic op; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct packed { logic [31:0] req; logic [31:0] data; } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [N*32-1:0]   req_a, req_b;
  logic [31:0]       rsp_data;
  logic              busy;

  op_t         pend_q [N][$];
  exp_t        sb_q [$];
  int          acc_cnt [N];
  int          taken [N];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  bit          rr_rand = 1'b0;
  logic [N-1:0] rr_force = '1;

  bit          m_busy = 1'b0;
  int          m_ptr = N - 1;
  int          m_grant = 0;
  int unsigned m_due = 0;

  addsub_share_arb #(.NUM_REQ(N), .EXEC_CYCLES(EC)) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic push(input int k, input logic op, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.op = op;
    o.a  = a;
    o.b  = b;
    pend_q[k].push_back(o);
  endtask

  // Advance one cycle and drive inputs 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      while (taken[k] < acc_cnt[k]) begin
        if (pend_q[k].size() > 0) void'(pend_q[k].pop_front());
        taken[k]++;
      end
      if (pend_q[k].size() > 0) begin
        req_valid[k]      = 1'b1;
        req_op[k]         = pend_q[k][0].op;
        req_a[k*32 +: 32] = pend_q[k][0].a;
        req_b[k*32 +: 32] = pend_q[k][0].b;
      end else begin
        req_valid[k]      = 1'b0;
        req_op[k]         = 1'($urandom);
        req_a[k*32 +: 32] = $urandom;
        req_b[k*32 +: 32] = $urandom;
      end
    end
    rsp_ready = rr_rand ? N'($urandom) : rr_force;
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (pend_q[k].size() > 0) return 1'b0;
    return sb_q.size() == 0;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!all_empty() && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) fail_now(name);
    repeat (2) step();
  endtask

  task automatic wait_acc(input int k, input string name);
    int base = acc_cnt[k];
    int n = 0;
    while (acc_cnt[k] == base && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) fail_now(name);
  endtask

  // Transaction-level model: one operation at a time, rotating priority.
  initial begin : model
    int g;
    logic [N-1:0] exp_ready, exp_rv;
    logic [31:0] a, b;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_ptr  = N - 1;
        sb_q.delete();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        continue;
      end
      g = -1;
      if (!m_busy) begin
        for (int i = 1; i <= N; i++) begin
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rv = (m_busy && cyc >= m_due) ? (N'(1) << m_grant) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        if (rsp_ready[m_grant]) m_busy = 1'b0;
      end else if (g >= 0) begin
        a = req_a[g*32 +: 32];
        b = req_b[g*32 +: 32];
        e.req  = 32'(g);
        e.data = req_op[g] ? (a - b) : (a + b);
        sb_q.push_back(e);
        m_busy  = 1'b1;
        m_grant = g;
        m_ptr   = g;
        m_due   = cyc + EC + 1;
        acc_cnt[g]++;
      end
    end
  end

  // Response monitor: compares every presented response with the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid != '0) begin
        if (sb_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = sb_q[0];
          check("rsp_data", rsp_data, e.data);
          check("rsp_target", 32'(rsp_valid), 32'(N'(1) << e.req));
          if (rsp_ready[e.req]) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int a0, tot;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    for (int k = 0; k < N; k++) begin acc_cnt[k] = 0; taken[k] = 0; end
    repeat (3) step();
    #2 rst_n = 1'b1;

    push(0, 1'b0, 32'd5, 32'd7);
    wait_idle("single_add");
    push(1, 1'b1, 32'd0, 32'd1);
    wait_idle("sub_wrap");
    push(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_idle("add_overflow");

    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 32'd1, 32'd1);
      push(1, 1'b1, 32'd9, 32'd4);
    end
    wait_idle("contention");
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < N; k++) push(k, 1'($urandom), rand_word(), rand_word());
    wait_idle("contention3");

    // Response backpressure with another requester waiting.
    rr_force = '0;
    push(0, 1'b1, 32'h100, 32'h23);
    wait_acc(0, "bp_grant");
    push(1, 1'b0, 32'h11, 32'h22);
    repeat (EC + 6) step();
    rr_force = '1;
    wait_idle("backpressure");

    // Ready from non-granted requesters must be ignored.
    rr_force = '0;
    push(0, 1'b0, 32'hAAAA_0000, 32'h0000_5555);
    wait_acc(0, "wr_grant");
    repeat (EC + 1) step();
    rr_force = ~N'(1);
    repeat (4) step();
    rr_force = N'(1);
    wait_idle("wrong_ready");
    rr_force = '1;

    // Asynchronous reset during the second execute cycle.
    for (int i = 0; i < 2; i++) begin
      push(0, 1'b0, 32'd3, 32'd4);
      push(1, 1'b1, 32'd3, 32'd4);
    end
    tot = acc_cnt[0] + acc_cnt[1];
    begin
      int n = 0;
      while (acc_cnt[0] + acc_cnt[1] == tot && n < 100) begin step(); n++; end
      if (n >= 100) fail_now("rst_grant");
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_rsp_data", rsp_data, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    step();
    step();
    a0  = acc_cnt[0];
    tot = acc_cnt[0] + acc_cnt[1];
    #2 rst_n = 1'b1;
    begin
      int n = 0;
      while (acc_cnt[0] + acc_cnt[1] == tot && n < 100) begin step(); n++; end
      if (n >= 100) fail_now("post_rst_grant");
    end
    check("post_rst_first_req0", 32'(acc_cnt[0] - a0), 32'd1);
    wait_idle("post_reset");

    rr_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++)
        if (pend_q[k].size() < 2 && $urandom_range(0, 3) == 0)
          push(k, 1'($urandom), rand_word(), rand_word());
      step();
    end
    rr_rand  = 1'b0;
    rr_force = '1;
    wait_idle("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
